// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter family: digit width, digit type,
// sequencing states and the digit sanitizer used on load.
package counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Non-decimal nibbles (A..F) saturate to 9 so the display never shows garbage.
  function automatic bcd_digit_t sanitize_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One mod-10 down-counting BCD digit. Load wins over decrement; a decrement
// from 0 wraps to 9 and raises borrow_out so the next digit steps down too.
module bcd_down_digit
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  bcd_digit_t digit_q, digit_d;

  // Next digit value: load, else decrement with 0 -> 9 wrap, else hold.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  // Digit register, cleared immediately by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec & (digit_q == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer. Loads a sanitized BCD start value, counts
// down one per enabled clock with decimal borrow, pulses done on reaching 0.
// Build option: define BCD_COUNTDOWN_RELOAD_EN for periodic mode, where the
// counter stays in RUN at 0 and the next enabled edge reloads load_val.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | count held regardless of on (reset state)
//   RUN   | decrementing on each on=1 edge
module bcd_countdown
  import counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    on,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] out,
  output logic                    zero,
  output logic                    done
);

  localparam int               W       = BCD_W * DIGITS;
  localparam logic [W-1:0]     CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic            dec0;
  logic            reload;
  logic            digit_load;
  logic [W-1:0]    load_san;
  logic            san_nonzero;
  logic            at_zero;
  logic            at_one;
  bcd_digit_t      digit_val [DIGITS];
  logic [DIGITS-1:0] borrow;
  logic            borrow_unused;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t dec_in;
    logic       dec_bit;

    assign load_san[i*BCD_W +: BCD_W] = sanitize_digit(load_val[i*BCD_W +: BCD_W]);
    assign dec_in                     = '0;

    if (i == 0) begin : g_lsd
      assign dec_bit = dec0;
    end else begin : g_upper
      assign dec_bit = borrow[i-1];
    end

    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .dec        (dec_bit),
      .load       (digit_load),
      .load_digit (load_san[i*BCD_W +: BCD_W]),
      .digit      (digit_val[i]),
      .borrow_out (borrow[i])
    );

    assign out[i*BCD_W +: BCD_W] = digit_val[i] | dec_in;
  end

  // The top digit never borrows because 0 is never decremented.
  assign borrow_unused = borrow[DIGITS-1];

  assign san_nonzero = (load_san != '0);
  assign at_zero     = (out == '0);
  assign at_one      = (out == CNT_ONE);
  assign digit_load  = load | reload;
  assign zero        = at_zero;
  assign done        = done_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load decides RUN/IDLE from the sanitized value; terminal count
  // returns to IDLE in one-shot mode and stays in RUN in periodic mode.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = san_nonzero ? RUN : IDLE;
    end else if ((state_q == RUN) && on && at_one) begin
`ifdef BCD_COUNTDOWN_RELOAD_EN
      state_d = RUN;
`else
      state_d = IDLE;
`endif
    end
  end

  // Datapath controls: decrement, periodic reload and the terminal-count pulse.
  always_comb begin
    dec0   = 1'b0;
    reload = 1'b0;
    done_d = 1'b0;
    if (!load && (state_q == RUN) && on) begin
      if (!at_zero) begin
        dec0   = 1'b1;
        done_d = at_one;
      end else begin
`ifdef BCD_COUNTDOWN_RELOAD_EN
        reload = 1'b1;
`else
        reload = 1'b0;
`endif
      end
    end
  end

  // Registered done pulse, high in the cycle out first reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_countdown.sv
module tb_bcd_countdown;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         on;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         zero;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: count as a plain integer, plus a running flag.
  int m_cnt  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  bcd_countdown #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .on       (on),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int san_value(input logic [W-1:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'((v >> (4 * i)) & 15);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_cnt = 0; m_run = 0; m_done = 0;
    end else if (load) begin
      m_cnt  = san_value(load_val);
      m_run  = (m_cnt != 0);
      m_done = 0;
    end else if (m_run && on) begin
      if (m_cnt > 0) begin
        m_cnt  = m_cnt - 1;
        m_done = (m_cnt == 0);
`ifndef BCD_COUNTDOWN_RELOAD_EN
        if (m_cnt == 0) m_run = 0;
`endif
      end else begin
        m_cnt  = san_value(load_val);
        m_done = 0;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_out"}, 32'(out), 32'(to_bcd(m_cnt)));
    check_val({tag, "_zero"}, 32'(zero), 32'(m_cnt == 0));
    check_val({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b0; on = 1'b0; load = 1'b0; load_val = '0;
    #2;
    check_outputs("por");
    #10 reset = 1'b1;

    // Countdown with borrow from 12.
    load = 1'b1; load_val = 8'h12;
    step("ld12");
    check_val("ld12_val", 32'(out), 32'h12);
    load = 1'b0; on = 1'b1;
    repeat (12) step("cd");
    check_val("cd_end_out", 32'(out), 32'h00);
    check_val("cd_end_done", 32'(done), 32'h1);
    repeat (2) step("cd_after");

    // Pause at 05.
    load = 1'b1; load_val = 8'h08; on = 1'b0;
    step("ld08");
    load = 1'b0; on = 1'b1;
    repeat (3) step("pre_pause");
    check_val("pause_at", 32'(out), 32'h05);
    on = 1'b0;
    repeat (3) step("pause");
    check_val("pause_hold", 32'(out), 32'h05);
    on = 1'b1;
    step("resume");
    check_val("resume_val", 32'(out), 32'h04);

    // Load overrides on; loading zero idles.
    load = 1'b1; load_val = 8'h09;
    step("ld09");
    load = 1'b0;
    repeat (2) step("to07");
    check_val("sim_at", 32'(out), 32'h07);
    load = 1'b1; load_val = 8'h42;
    step("sim_ld");
    check_val("sim_val", 32'(out), 32'h42);
    check_val("sim_done", 32'(done), 32'h0);
    load_val = 8'h00;
    step("ld00");
    check_val("ld00_val", 32'(out), 32'h00);
    check_val("ld00_done", 32'(done), 32'h0);
    load = 1'b0;
    repeat (3) step("idle0");

    // Invalid BCD saturates per digit.
    load = 1'b1; load_val = 8'hAF; on = 1'b0;
    step("ldAF");
    check_val("ldAF_val", 32'(out), 32'h99);
    load = 1'b0; on = 1'b1;
    step("dec99");
    check_val("dec99_val", 32'(out), 32'h98);

    // Asynchronous reset mid-count.
    load = 1'b1; load_val = 8'h37; on = 1'b0;
    step("ld37");
    load = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_edge();
    check_outputs("arst");
    step("arst_hold");
    #2 reset = 1'b1; on = 1'b1;
    repeat (3) step("post_rst");

`ifdef BCD_COUNTDOWN_RELOAD_EN
    // Periodic reload: 02, 01, 00, 02, 01, 00.
    load = 1'b1; load_val = 8'h02;
    step("per_ld");
    load = 1'b0;
    repeat (8) step("per");
`endif

    // Randomized traffic against the model.
    repeat (3000) begin
      on       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Multi-digit BCD down-counter (countdown timer) built as the counting-down counterpart of the team's mod-10 up-counter. It loads a BCD start value, decrements by one per enabled clock with decimal borrow between digits, and flags terminal count with a one-cycle `done` pulse. Its `out` bus drives the same digit display and decode logic that the mod-10 counter feeds.

## Interface
- `DIGITS`, default 2: number of BCD digits. Legal range 1–8.
- `clk`  input  1: single clock. All state changes on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `on`  input  1: count enable. Counting is paused while low.
- `load`  input  1: synchronous load strobe.
- `load_val`  input  4*DIGITS: BCD start value. Digit 0 occupies bits [3:0].
- `out`  output  4*DIGITS: current BCD count, registered.
- `zero`  output  1: high when `out` equals 0. Decoded directly from the `out` register.
- `done`  output  1: registered one-cycle pulse on reaching terminal count.

## Operation
- FSM has two states:
  - IDLE: count held. Reset state.
  - RUN: decrementing.
- Priority order each edge: `reset` low, then `load`, then `on`.
- Load behaviour (`load`=1):
  - `out` <= sanitized `load_val`. Sanitizing saturates any digit greater than 9 to 9.
  - Next state is RUN if the sanitized value is nonzero, otherwise IDLE.
  - `done` is 0 on a load cycle, including a load of zero.
  - `load` overrides `on`, so no decrement occurs that cycle. A load during RUN restarts the count immediately.
- RUN with `on`=1 and `out`≠0:
  - BCD decrement by 1.
  - Digit 0 decrements. A digit at 0 wraps to 9 and asserts borrow to the next digit.
  - The borrow ripples combinationally through all digits within one cycle.
- Terminal count, `out`=1 (all upper digits 0, digit 0 = 1) decremented with `on`=1:
  - `out` <= 0 and `done` <= 1 for exactly that one cycle.
  - Next state is IDLE (see Configuration for the reload variant).
- RUN with `on`=0: `out` holds, `done`=0, state holds.
- IDLE: `out` holds regardless of `on`. `done`=0.
- No underflow is possible: 0 never decrements to all-nines.

## Timing
- Reset values: `out`=0, `zero`=1, `done`=0, state IDLE. Reset takes effect immediately, with no clock required.
- Reset released mid-count resumes from IDLE with count 0.
- Load latency is 1 cycle: `out` shows the loaded value on the edge after `load` is sampled.
- Decrement latency is 1 cycle per enabled edge. A load of N followed by continuous `on` reaches 0 after N cycles.
- `done` is high in the same cycle that `out` first reads 0.
- `zero` has no additional latency relative to `out`.

## Configuration
- Macro `BCD_COUNTDOWN_RELOAD_EN`:
  - Defined: periodic mode. At `out`=0 the FSM stays in RUN. The next `on`=1 edge reloads the sanitized `load_val`, and the reload cycle itself does not decrement. Period is N+1 enabled cycles, with `done` pulsing once per period. If `load_val` is 0 in this mode, `out` holds 0 and `done` stays low.
  - Undefined: one-shot mode as in Operation. The counter holds at 0 in IDLE until the next `load`.

## Structure
- Shared package `counter_pkg` holds:
  - `BCD_W`=4
  - `BCD_MAX`=4'd9
  - a `bcd_digit_t` typedef
  - a state enum {IDLE, RUN}
- Sub-module `bcd_down_digit`: one mod-10 down digit.
  - Inputs: `dec`, `load`, sanitized load digit.
  - Outputs: digit value and `borrow_out`, asserted when `dec` is high and the digit is 0.
  - Instantiated DIGITS times and chained `borrow_out` → `dec`. Digit 0's `dec` is driven by the FSM.

## Test plan
All scenarios use `DIGITS`=2.
- Reset: pull `reset` low mid-count at 0x37 without a clock edge → immediately `out`=0x00, `zero`=1, `done`=0. After release with `on`=1 and no load, `out` stays 0x00.
- Countdown with borrow: load 0x12, then `on`=1 → `out` reads 0x11, 0x10, 0x09 … 0x01, 0x00. `done`=1 only on the 0x00 cycle. Afterwards `out` holds 0x00 and `done`=0.
- Pause: drop `on` at 0x05 for 3 cycles → `out` holds 0x05 throughout. Restore `on` → 0x04 on the next edge.
- Simultaneous events: at `out`=0x07, assert `load`=1 with 0x42 and `on`=1 → next `out`=0x42, `done`=0. Loading 0x00 → IDLE, `done`=0.
- Invalid BCD: load 0xAF → `out`=0x99, and the next enabled edge gives 0x98.
- With `BCD_COUNTDOWN_RELOAD_EN`: load 0x02, `on`=1 → `out` reads 02, 01, 00 (with `done`), 02, 01, 00 (with `done`), repeating indefinitely.
